// File: rtl/mips32_prog_loader_pkg.sv
// Shared definitions for the MIPS32 program loader and the pipelined core.
// Holds the instruction opcode constants used by both sides (the loader only
// needs HLT to spot the end of a program) and the loader state encoding.
package mips32_prog_loader_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_SLT  = 6'h04;
    localparam logic [5:0] OP_MUL  = 6'h05;
    localparam logic [5:0] OP_LW   = 6'h08;
    localparam logic [5:0] OP_SW   = 6'h09;
    localparam logic [5:0] OP_ADDI = 6'h0a;
    localparam logic [5:0] OP_SUBI = 6'h0b;
    localparam logic [5:0] OP_SLTI = 6'h0c;
    localparam logic [5:0] OP_BNEQZ = 6'h0d;
    localparam logic [5:0] OP_BEQZ = 6'h0e;
    localparam logic [5:0] OP_HLT  = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/mips32_byte_packer.sv
// 8->32 big-endian packer. The first accepted byte of a word lands in
// bits [31:24], the fourth in [7:0].
// Ports:
//   clk1       - system clock
//   rst        - synchronous active-high reset (clears the byte index)
//   clr        - synchronous clear of the byte index (start of a new load)
//   byte_vld   - a byte is accepted this cycle
//   byte_in    - the accepted byte
//   word_o     - assembled word; meaningful in the cycle word_valid is high
//   word_valid - pulse in the cycle the fourth byte of a word is accepted
module mips32_byte_packer (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_o,
    output logic        word_valid
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] buf_q, buf_d;

    always_comb begin
        idx_d = idx_q;
        buf_d = buf_q;
        if (clr) begin
            idx_d = 2'd0;
        end else if (byte_vld) begin
            idx_d = idx_q + 2'd1;
            buf_d = {buf_q[15:0], byte_in};
        end
    end

    // The last byte bypasses the buffer so the full word is available in the
    // same cycle it completes; the index wraps to 0 for the next word.
    assign word_o     = {buf_q, byte_in};
    assign word_valid = byte_vld && (idx_q == 2'd3);

    always_ff @(posedge clk1) begin
        if (rst) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk1) begin
        buf_q <= buf_d;
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Boot-time program loader for the MIPS32 core memory. Assembles a byte
// stream into big-endian words, writes them to addresses 0,1,2,... and keeps
// the core stalled until a HLT word has been written.
// Ports:
//   clk1, rst             - clock, synchronous active-high reset
//   start                 - pulse starting a load (IDLE/DONE/ERR only)
//   in_valid/in_byte      - upstream byte stream, in_ready is the handshake
//   mem_we/addr/wdata     - single-cycle write port into core memory
//   cpu_hold              - core stall while no complete program is loaded
//   done / err            - HLT written / MAX_WORDS written without HLT
//   word_count            - words written in the current or last load
module mips32_prog_loader
    import mips32_prog_loader_pkg::*;
#(
    parameter int         ADDR_W     = 10,
    parameter int         MAX_WORDS  = 1024,
    parameter logic [5:0] HLT_OPCODE = OP_HLT
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        pk_clr;
    logic        byte_acc;
    logic [31:0] pk_word;
    logic        pk_word_valid;

    assign byte_acc = in_valid && (state_q == ST_LOAD);

    mips32_byte_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .clr        (pk_clr),
        .byte_vld   (byte_acc),
        .byte_in    (in_byte),
        .word_o     (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        word_count_d = word_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pk_clr       = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    next_addr_d  = '0;
                    word_count_d = '0;
                    pk_clr       = 1'b1;
                end
            end
            ST_LOAD: begin
                // Latch address and word on entry to WRITE so the memory port
                // only changes when a write is actually issued.
                if (pk_word_valid) begin
                    state_d     = ST_WRITE;
                    mem_addr_d  = next_addr_q;
                    mem_wdata_d = pk_word;
                end
            end
            ST_WRITE: begin
                word_count_d = word_count_q + CNT_ONE;
                if (mem_wdata_q[31:26] == HLT_OPCODE) begin
                    state_d = ST_DONE;
                end else if (word_count_d == MAX_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    next_addr_d = next_addr_q + ADDR_ONE;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            next_addr_q  <= '0;
            word_count_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            word_count_q <= word_count_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_hold   = (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
module tb_mips32_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_byte;

    logic        rdy_a, we_a, hold_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a;
    logic [10:0] wc_a;

    logic        rdy_b, we_b, hold_b, done_b, err_b;
    logic [9:0]  addr_b;
    logic [31:0] wd_b;
    logic [10:0] wc_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [41:0] log_a[$];
    logic [41:0] log_b[$];
    logic        prev_we_a = 1'b0;
    logic        prev_we_b = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t prog[9];

    always #5 clk1 = ~clk1;

    mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut_a (
        .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_a), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .cpu_hold(hold_a), .done(done_a), .err(err_a), .word_count(wc_a)
    );

    mips32_prog_loader #(.ADDR_W(10), .MAX_WORDS(4)) dut_b (
        .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(rdy_b), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .cpu_hold(hold_b), .done(done_b), .err(err_b), .word_count(wc_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (we_a) begin
            chk("we_a_back_to_back", {63'd0, prev_we_a}, 64'd0);
            log_a.push_back({addr_a, wd_a});
        end
        if (we_b) begin
            chk("we_b_back_to_back", {63'd0, prev_we_b}, 64'd0);
            log_b.push_back({addr_b, wd_b});
        end
        prev_we_a <= we_a;
        prev_we_b <= we_b;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit on_b, output int acc_at);
        bit acc;
        acc = 1'b0;
        acc_at = -1;
        if (gap) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_byte  = b;
        for (int n = 0; n < 40 && !acc; n++) begin
            if (on_b ? rdy_b : rdy_a) begin
                acc = 1'b1;
                acc_at = cyc;
            end
            tick();
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL byte_accept: got no accept want accept of %0h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input bit on_b, output int first_at);
        int t;
        logic [31:0] wv;
        wv = w;
        send_byte(wv[31:24], gap, on_b, first_at);
        send_byte(wv[23:16], gap, on_b, t);
        send_byte(wv[15:8],  gap, on_b, t);
        send_byte(wv[7:0],   gap, on_b, t);
    endtask

    task automatic wait_done_a(output int at);
        at = -1;
        for (int n = 0; n < 30 && at < 0; n++) begin
            if (done_a) at = cyc;
            else tick();
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL wait_done: got done=0 want done=1");
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_in_ready"}, {63'd0, rdy_a}, 64'd0);
        chk({tag, "_mem_we"}, {63'd0, we_a}, 64'd0);
        chk({tag, "_mem_addr"}, {54'd0, addr_a}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, wd_a}, 64'd0);
        chk({tag, "_cpu_hold"}, {63'd0, hold_a}, 64'd1);
        chk({tag, "_done"}, {63'd0, done_a}, 64'd0);
        chk({tag, "_err"}, {63'd0, err_a}, 64'd0);
        chk({tag, "_word_count"}, {53'd0, wc_a}, 64'd0);
    endtask

    initial begin
        int t0, t1, td;
        logic [41:0] e;
        int r[32];
        logic [31:0] d;

        prog[0] = '{32'h2801000a, 10'd0};
        prog[1] = '{32'h28020014, 10'd1};
        prog[2] = '{32'h28030019, 10'd2};
        prog[3] = '{32'h0ce73800, 10'd3};
        prog[4] = '{32'h0ce73800, 10'd4};
        prog[5] = '{32'h00222000, 10'd5};
        prog[6] = '{32'h0ce73800, 10'd6};
        prog[7] = '{32'h00832800, 10'd7};
        prog[8] = '{32'hfc000000, 10'd8};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        tick(); tick();
        chk_reset_a("reset");
        rst = 1'b0;
        tick();

        // Two words back to back, measure latency to DONE
        log_a.delete();
        do_start();
        send_word(32'h2801000a, 1'b0, 1'b0, t0);
        send_word(32'hfc000000, 1'b0, 1'b0, t1);
        in_valid = 1'b0;
        wait_done_a(td);
        chk("bb_latency", 64'(td - t0), 64'd10);
        chk("bb_nwrites", 64'(log_a.size()), 64'd2);
        if (log_a.size() == 2) begin
            chk("bb_w0", {22'd0, log_a[0]}, {22'd0, 10'd0, 32'h2801000a});
            chk("bb_w1", {22'd0, log_a[1]}, {22'd0, 10'd1, 32'hfc000000});
        end
        chk("bb_done", {63'd0, done_a}, 64'd1);
        chk("bb_hold", {63'd0, hold_a}, 64'd0);
        chk("bb_count", {53'd0, wc_a}, 64'd2);

        // Nine-word program with random valid gaps
        log_a.delete();
        do_start();
        for (int i = 0; i < 9; i++) send_word(prog[i].word, 1'b1, 1'b0, t0);
        in_valid = 1'b0;
        wait_done_a(td);
        chk("prog_nwrites", 64'(log_a.size()), 64'd9);
        for (int i = 0; i < 9 && i < log_a.size(); i++) begin
            e = log_a[i];
            chk($sformatf("prog_addr%0d", i), {54'd0, e[41:32]}, {54'd0, prog[i].exp_addr});
            chk($sformatf("prog_data%0d", i), {32'd0, e[31:0]}, {32'd0, prog[i].word});
        end
        chk("prog_count", {53'd0, wc_a}, 64'd9);
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < log_a.size(); i++) begin
            e = log_a[i];
            d = e[31:0];
            if (d[31:26] == 6'h3f) break;
            case (d[31:26])
                6'h0a: if (d[20:16] != 0) r[d[20:16]] = r[d[25:21]] + int'($signed(d[15:0]));
                6'h00: if (d[15:11] != 0) r[d[15:11]] = r[d[25:21]] + r[d[20:16]];
                6'h03: if (d[15:11] != 0) r[d[15:11]] = r[d[25:21]] | r[d[20:16]];
                default: ;
            endcase
        end
        chk("prog_r4", 64'(r[4]), 64'd30);
        chk("prog_r5", 64'(r[5]), 64'd55);

        // Restart from DONE, then start pulses during LOAD and WRITE
        do_start();
        chk("restart_count", {53'd0, wc_a}, 64'd0);
        chk("restart_hold", {63'd0, hold_a}, 64'd1);
        chk("restart_done", {63'd0, done_a}, 64'd0);
        log_a.delete();
        send_byte(8'h28, 1'b0, 1'b0, t0);
        send_byte(8'h01, 1'b0, 1'b0, t0);
        start = 1'b1;
        send_byte(8'h00, 1'b0, 1'b0, t0);
        start = 1'b0;
        send_byte(8'h0a, 1'b0, 1'b0, t0);
        chk("sw_in_write", {63'd0, we_a}, 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(32'h00222000, 1'b0, 1'b0, t0);
        send_word(32'hfc000000, 1'b0, 1'b0, t0);
        in_valid = 1'b0;
        wait_done_a(td);
        chk("sw_nwrites", 64'(log_a.size()), 64'd3);
        if (log_a.size() == 3) begin
            chk("sw_w0", {22'd0, log_a[0]}, {22'd0, 10'd0, 32'h2801000a});
            chk("sw_w1", {22'd0, log_a[1]}, {22'd0, 10'd1, 32'h00222000});
            chk("sw_w2", {22'd0, log_a[2]}, {22'd0, 10'd2, 32'hfc000000});
        end
        chk("sw_count", {53'd0, wc_a}, 64'd3);

        // Reset mid-load, then HLT as the first word
        do_start();
        log_a.delete();
        send_word(32'h28010005, 1'b0, 1'b0, t0);
        send_byte(8'h28, 1'b0, 1'b0, t0);
        send_byte(8'h02, 1'b0, 1'b0, t0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset_a("midrst");
        chk("midrst_nwrites", 64'(log_a.size()), 64'd1);
        rst = 1'b0;
        tick();
        log_a.delete();
        do_start();
        send_word(32'hfc123456, 1'b0, 1'b0, t0);
        in_valid = 1'b0;
        wait_done_a(td);
        chk("hlt1_nwrites", 64'(log_a.size()), 64'd1);
        if (log_a.size() == 1) chk("hlt1_w0", {22'd0, log_a[0]}, {22'd0, 10'd0, 32'hfc123456});
        chk("hlt1_done", {63'd0, done_a}, 64'd1);
        chk("hlt1_count", {53'd0, wc_a}, 64'd1);

        // Overflow on the MAX_WORDS=4 instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_b.delete();
        do_start();
        for (int i = 0; i < 4; i++) send_word(32'h01020300 + 32'(i), 1'b0, 1'b1, t0);
        in_valid = 1'b0;
        tick(); tick();
        chk("ovf_err", {63'd0, err_b}, 64'd1);
        chk("ovf_hold", {63'd0, hold_b}, 64'd1);
        chk("ovf_ready", {63'd0, rdy_b}, 64'd0);
        chk("ovf_count", {53'd0, wc_b}, 64'd4);
        in_valid = 1'b1;
        in_byte  = 8'h05;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ovf_noaccept%0d", i), {63'd0, rdy_b}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("ovf_nwrites", 64'(log_b.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_b.size(); i++) begin
            e = log_b[i];
            chk($sformatf("ovf_w%0d", i), {22'd0, e}, {22'd0, 10'(i), 32'h01020300 + 32'(i)});
        end
        do_start();
        chk("ovf_restart_err", {63'd0, err_b}, 64'd0);
        chk("ovf_restart_ready", {63'd0, rdy_b}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Boot-time program loader sitting directly upstream of the MIPS32 pipelined core's instruction/data memory (Mem).
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive memory addresses from 0 and holds the core until a HLT word (opcode 6'h3f) has been written.
- Replaces direct pre-loading of Mem with a synthesizable load path.

Parameters:
ADDR_W, 10, width of memory word address
MAX_WORDS, 1024, max words accepted before overflow error (must be <= 2**ADDR_W)
HLT_OPCODE, 6'h3f, opcode in bits [31:26] that terminates the load

Ports:
clk1  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse, begins a load (honoured in IDLE, DONE, ERR only)
in_valid  input  1  upstream byte valid
in_byte  input  8  upstream byte, MSB-first within each word
in_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  one-cycle write strobe to core memory
mem_addr  output  ADDR_W  word address of the write
mem_wdata  output  32  assembled word
cpu_hold  output  1  1 = core must stall (gates the core's HLT/PC advance)
done  output  1  load completed with HLT written
err  output  1  MAX_WORDS written without HLT
word_count  output  ADDR_W+1  number of words written in the current or last load

Behaviour:
- Reset is synchronous and active-high on clk1 and wins over all other inputs.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0.
- A reset asserted mid-load abandons any partial word and returns to IDLE. No write is issued in the reset cycle.
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE: in_ready=0, cpu_hold=1. On start -> LOAD; clear byte index, word_count and next address to 0.
- LOAD: in_ready=1.
  - A byte is accepted when in_valid && in_ready.
  - Byte index 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - Gaps in in_valid stall with no state change.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle): in_ready=0, mem_we=1, mem_addr=next address, mem_wdata=assembled word. word_count increments in this cycle (registered, visible the following cycle). Exit:
  - If mem_wdata[31:26]==HLT_OPCODE -> DONE.
  - Else if word_count (after increment) == MAX_WORDS -> ERR.
  - Else address+1 -> LOAD.
- DONE: cpu_hold=0, done=1, in_ready=0. On start -> LOAD with done cleared and cpu_hold=1 in the same transition.
- ERR: cpu_hold=1, err=1, in_ready=0. Only start or rst leaves ERR; start -> LOAD with err cleared.
- start is ignored in LOAD and WRITE.
- in_valid bytes outside LOAD are not accepted (in_ready=0) and are not buffered.
- Throughput: minimum 5 clk1 cycles per word (4 accepts + 1 write). Latency from 4th byte accept to mem_we is 1 cycle.
- mem_we is never asserted for two consecutive cycles. mem_addr and mem_wdata are don't-care-stable (hold last value) when mem_we=0.
- HLT opcode in any word position ends the load. Words following HLT in the stream are left untouched for the next load.

Decomposition:
- Shared package/header: opcode constants (HLT=6'h3f, ADD, ADDI, OR, ...) shared with the core, and the loader state encoding.
- One natural sub-module, mips32_byte_packer: 8->32 big-endian packer with byte index counter, clear input, and word_valid pulse.
- Top holds the FSM, address counter and status outputs.

Test Plan:
- Load 2801000a then fc000000 with back-to-back valid bytes.
  -> mem_we at addr 0 data 32'h2801000a, then addr 1 data 32'hfc000000.
  -> done=1, cpu_hold=0, word_count=2.
  -> Exactly 10 cycles from first accept to DONE entry.
- Same 9-word program (ADDI R1/R2/R3, OR R7 x2, ADD R4, OR, ADD R5, HLT) with random in_valid gaps.
  -> Addresses 0..8 written with exact words; word_count=9; no extra writes.
  -> Core then yields R4=30, R5=55.
- MAX_WORDS=4, stream 5 non-HLT words.
  -> 4 writes (addr 0..3), err=1, cpu_hold=1, in_ready=0.
  -> 5th word bytes not accepted.
- Assert rst after 2 bytes of word 1 (word 0 already written).
  -> Next cycle all outputs at reset values, no mem_we.
  -> A new start plus stream writes from addr 0.
- start pulsed during LOAD and during WRITE.
  -> Ignored; addresses and word_count continue unchanged.
  -> A later start in DONE restarts: word_count=0, cpu_hold=1, done=0.
- Word 32'hfc123456 as first word.
  -> Treated as HLT: single write at addr 0, done=1, word_count=1.
